ntt_cmd_sequencer: RTL and testbench

NTT_CMD_SEQUENCER -- requirements
Module: ntt_cmd_sequencer

---
 rtl/ntt_cmd_sequencer.sv | 116 +++++++++++
 tb/tb_ntt_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_cmd_sequencer.sv
// ntt_cmd_sequencer: turns queued commands into an NTT core op pulse, data beats and a post-command wait
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready handshake carrying cmd_op, cmd_len, cmd_hold, cmd_wait
//   s_valid/s_ready/s_data   input word stream, passed straight through to din0
//   op_code, din_valid, din0 drive the NTT core; ntt_done is its done level
//   busy, cmd_done (1-cycle pulse), all_done (ntt_done delayed by one cycle)
module ntt_cmd_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10,
    parameter int WAIT_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_hold,
    input  logic [WAIT_W-1:0] cmd_wait,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [4:0]        op_code,
    output logic              din_valid,
    output logic [DATA_W-1:0] din0,
    input  logic              ntt_done,
    output logic              busy,
    output logic              cmd_done,
    output logic              all_done
);
    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, GAP, WAIT} state_t;
    state_t            state;
    logic              hold;
    logic [LEN_W-1:0]  cnt;
    logic [WAIT_W-1:0] wcnt;
    logic [DATA_W-1:0] last;
    logic              beat;
    assign beat      = (state == STREAM) && (hold || s_valid);
    assign din_valid = ((state == ISSUE) && hold) || beat;
    // s_ready is high exactly in STREAM with hold=0; bubbles keep the last streamed word on din0
    assign din0      = s_ready ? (s_valid ? s_data : last) : '0;
    // cmd_done is registered, so it is set on the edge entering its final cycle:
    // GAP when no wait follows, otherwise the WAIT cycle whose counter reads 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold      <= 1'b0;
            cnt       <= '0;
            wcnt      <= '0;
            last      <= '0;
            cmd_ready <= 1'b0;
            s_ready   <= 1'b0;
            op_code   <= '0;
            busy      <= 1'b0;
            cmd_done  <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            op_code  <= '0;
            cmd_done <= 1'b0;
            all_done <= ntt_done;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= ISSUE;
                        op_code   <= cmd_op;
                        hold      <= cmd_hold;
                        cnt       <= cmd_len;
                        wcnt      <= cmd_wait;
                        last      <= '0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= (cnt != '0) ? STREAM : GAP;
                    s_ready  <= (cnt != '0) && !hold;
                    cmd_done <= (cnt == '0) && (wcnt == '0);
                end
                STREAM: begin
                    if (beat) begin
                        cnt <= cnt - LEN_W'(1);
                        if (!hold) last <= s_data;
                        if (cnt == LEN_W'(1)) begin
                            state    <= GAP;
                            s_ready  <= 1'b0;
                            cmd_done <= wcnt == '0;
                        end
                    end
                end
                GAP: begin
                    if (wcnt != '0) begin
                        state    <= WAIT;
                        cmd_done <= wcnt == WAIT_W'(1);
                    end else begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    wcnt     <= wcnt - WAIT_W'(1);
                    cmd_done <= wcnt == WAIT_W'(2);
                    if (wcnt == WAIT_W'(1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// tb_ntt_cmd_sequencer: directed checks of the NTT command sequencer
module tb_ntt_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_op = '0;
    logic [9:0]  cmd_len = '0;
    logic        cmd_hold = 1'b0;
    logic [11:0] cmd_wait = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [4:0]  op_code;
    logic        din_valid;
    logic [31:0] din0;
    logic        ntt_done = 1'b0;
    logic        busy;
    logic        cmd_done;
    logic        all_done;

    int checks = 0;
    int errors = 0;
    int done_at, ndv, dv_last, nop, nsr;

    ntt_cmd_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_hold(cmd_hold), .cmd_wait(cmd_wait),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .op_code(op_code), .din_valid(din_valid), .din0(din0),
        .ntt_done(ntt_done), .busy(busy), .cmd_done(cmd_done), .all_done(all_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] op, input logic [9:0] len, input logic hold, input logic [11:0] wt);
        int k;
        cmd_op = op; cmd_len = len; cmd_hold = hold; cmd_wait = wt; cmd_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) chk("send_rdy", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // cycle numbers count from 1 at the ISSUE cycle
    task automatic run_cmd(input logic [4:0] op, input logic [9:0] len, input logic hold, input logic [11:0] wt);
        send(op, len, hold, wt);
        done_at = 0; ndv = 0; dv_last = 0; nop = 0; nsr = 0;
        for (int n = 1; n < 6000; n++) begin
            @(negedge clk);
            if (op_code != 0) nop++;
            if (din_valid) begin ndv++; dv_last = n; end
            if (s_ready) nsr++;
            if (cmd_done) begin done_at = n; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] words [3];
        int bad, beats, ops, seen;
        logic ph;
        words[0] = 32'h1; words[1] = 32'hD01; words[2] = 32'hCF9;

        // reset state
        @(negedge clk);
        chk("rst_op", op_code, 0);
        chk("rst_dv", din_valid, 0);
        chk("rst_din0", din0, 0);
        chk("rst_srdy", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_all", all_done, 0);
        chk("rst_crdy", cmd_ready, 0);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); chk("rel_crdy0", cmd_ready, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("rel_crdy1", cmd_ready, 1);
        @(posedge clk); #1;

        // load params, continuous stream
        s_valid = 1'b1; s_data = words[0];
        send(5'd1, 10'd3, 1'b0, 12'd0);
        @(negedge clk);
        chk("lp_op", op_code, 1);
        chk("lp_issue_dv", din_valid, 0);
        chk("lp_issue_crdy", cmd_ready, 0);
        chk("lp_issue_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; s_data = words[i];
            @(negedge clk);
            chk("lp_dv", din_valid, 1);
            chk("lp_din0", din0, words[i]);
            chk("lp_srdy", s_ready, 1);
            chk("lp_op0", op_code, 0);
            chk("lp_nodone", cmd_done, 0);
        end
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk);
        chk("lp_gap_dv", din_valid, 0);
        chk("lp_gap_srdy", s_ready, 0);
        chk("lp_gap_done", cmd_done, 1);
        chk("lp_gap_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lp_idle_done", cmd_done, 0);
        chk("lp_idle_busy", busy, 0);
        chk("lp_idle_crdy", cmd_ready, 1);
        @(posedge clk); #1;

        // load W with stalls: s_valid toggles every cycle
        s_valid = 1'b0;
        send(5'd2, 10'd504, 1'b0, 12'd0);
        bad = 0; beats = 0; ops = 0; seen = 0; ph = 1'b0;
        for (int c = 0; c < 1300 && seen == 0; c++) begin
            @(negedge clk);
            if (op_code != 0) ops++;
            if (din_valid) begin
                if (din0 != 32'hA000_0000 + beats) bad++;
                beats++;
            end else if (s_ready && beats > 0 && din0 != 32'hA000_0000 + beats - 1) bad++;
            if (cmd_done) seen = 1;
            @(posedge clk); #1;
            ph = ~ph; s_valid = ph; s_data = 32'hA000_0000 + beats;
        end
        s_valid = 1'b0;
        chk("w_beats", beats, 504);
        chk("w_order", bad, 0);
        chk("w_ops", ops, 1);
        chk("w_done", seen, 1);
        @(posedge clk); #1;

        // start NTT: no data, 138 wait cycles
        run_cmd(5'd4, 10'd0, 1'b0, 12'd138);
        chk("st_done_at", done_at, 140);
        chk("st_dv", ndv, 0);
        chk("st_ops", nop, 1);

        // hold mode, stream offered but never consumed
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        run_cmd(5'd12, 10'd121, 1'b1, 12'd0);
        chk("hd_dv", ndv, 122);
        chk("hd_dv_last", dv_last, 122);
        chk("hd_srdy", nsr, 0);
        chk("hd_done_at", done_at, 123);

        // short hold with a single wait cycle
        run_cmd(5'd5, 10'd2, 1'b1, 12'd1);
        chk("hw_dv", ndv, 3);
        chk("hw_done_at", done_at, 5);

        // maximum len and maximum wait
        run_cmd(5'd3, 10'd1023, 1'b1, 12'd0);
        chk("ml_dv", ndv, 1024);
        chk("ml_done_at", done_at, 1025);
        s_valid = 1'b0;
        run_cmd(5'd4, 10'd0, 1'b0, 12'd4095);
        chk("mw_done_at", done_at, 4097);
        chk("mw_ops", nop, 1);

        // reset mid-stream after 10 of 256 beats
        s_valid = 1'b1; s_data = 32'h55;
        send(5'd1, 10'd256, 1'b0, 12'd0);
        for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
        @(negedge clk); chk("rs_pre_dv", din_valid, 1);
        @(posedge clk); #1; reset = 1'b0; #1;
        chk("rs_dv", din_valid, 0);
        chk("rs_din0", din0, 0);
        chk("rs_srdy", s_ready, 0);
        chk("rs_busy", busy, 0);
        chk("rs_crdy", cmd_ready, 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cmd_done) seen = 1;
        end
        chk("rs_nodone", seen, 0);
        @(posedge clk); #1; reset = 1'b1;
        run_cmd(5'd1, 10'd1, 1'b0, 12'd0);
        chk("rs_new_done_at", done_at, 3);
        chk("rs_new_dv", ndv, 1);
        s_valid = 1'b0;

        // busy hold-off with cmd_valid held high, then back-to-back accept
        cmd_op = 5'd1; cmd_len = 10'd0; cmd_hold = 1'b0; cmd_wait = 12'd3; cmd_valid = 1'b1;
        @(negedge clk); chk("ho_idle_crdy", cmd_ready, 1);
        @(posedge clk); #1; cmd_op = 5'd2; cmd_wait = 12'd0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk("ho_crdy", cmd_ready, 0);
            chk("ho_done", cmd_done, n == 5);
            if (n == 1) chk("ho_op1", op_code, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("ho_idle2_crdy", cmd_ready, 1);
        chk("ho_idle2_busy", busy, 0);
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        chk("ho_op2", op_code, 2);
        chk("ho_busy2", busy, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("ho_done2", cmd_done, 1);
        @(posedge clk); #1;

        // all_done follows ntt_done one cycle later
        ntt_done = 1'b1;
        @(negedge clk); chk("ad_0", all_done, 0);
        @(posedge clk); #1; ntt_done = 1'b0;
        @(negedge clk); chk("ad_1", all_done, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("ad_2", all_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
